// File: rtl/param_alu_if.sv
// Operand/handshake bundle between an ALU requester and param_alu.
// The requester drives operands, opcode and start; the ALU returns busy, done and result.
interface param_alu_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output A, B, op, start,
    input  busy, done, result
  );

  modport slave (
    input  A, B, op, start,
    output busy, done, result
  );
endinterface

// File: rtl/param_alu.sv
// WIDTH-bit ALU with start/done handshake, pipelined multiplier of MUL_LATENCY
// cycles, and an internal accumulator used by multiply-accumulate.
module param_alu #(
  parameter int WIDTH       = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  param_alu_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(MUL_LATENCY);
  localparam int PS = MUL_LATENCY - 1;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    SUB_OP = 3'b101,
    MAC_OP = 3'b110,
    RST_OP = 3'b111
  } op_e;

  typedef enum logic [1:0] {IDLE, SINGLE, MULT, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    result_q, result_d;
  logic [RW-1:0]    prod_q [PS];

  op_e              op_in;
  logic             accept;
  logic [WIDTH:0]   diff;
  logic [RW-1:0]    mac_sum;

  assign op_in   = op_e'(bus.op);
  assign accept  = (state_q == IDLE || state_q == DONE) && bus.start && (op_in != NO_OP);
  assign diff    = {1'b0, a_q} - {1'b0, b_q};
  assign mac_sum = acc_q + prod_q[PS-1];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = (op_in == MUL_OP || op_in == MAC_OP) ? MULT : SINGLE;
          cnt_d   = '0;
        end
      end
      SINGLE: begin
        state_d = DONE;
        case (op_q)
          ADD_OP:  result_d = RW'({1'b0, a_q} + {1'b0, b_q});
          AND_OP:  result_d = RW'(a_q & b_q);
          XOR_OP:  result_d = RW'(a_q ^ b_q);
          SUB_OP:  result_d = {{(RW-WIDTH-1){diff[WIDTH]}}, diff};
          RST_OP: begin
            result_d = '0;
            acc_d    = '0;
          end
          default: result_d = result_q;
        endcase
      end
      MULT: begin
        cnt_d = cnt_q + CW'(1);
        // The last pipeline stage holds the product by the time the count expires.
        if (cnt_q == CW'(MUL_LATENCY - 1)) begin
          state_d = DONE;
          if (op_q == MAC_OP) begin
            acc_d    = mac_sum;
            result_d = mac_sum;
          end else begin
            result_d = prod_q[PS-1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= NO_OP;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      if (accept) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= op_in;
      end
    end
  end

  // NOTE: the product pipeline is reset as well, so an aborted multiply leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PS; i++) prod_q[i] <= '0;
    end else begin
      prod_q[0] <= RW'(a_q) * RW'(b_q);
      for (int i = 1; i < PS; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign bus.busy   = (state_q == SINGLE) || (state_q == MULT);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_param_alu.sv
// Directed-vector bench for param_alu (WIDTH=8, MUL_LATENCY=3) with
// hand-computed expected results.
module tb_param_alu;
  localparam int WIDTH = 8;
  localparam int LAT   = 3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MAC = 3'b110;
  localparam logic [2:0] OP_RST = 3'b111;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  param_alu_if #(.WIDTH(WIDTH)) bus ();

  param_alu #(.WIDTH(WIDTH), .MUL_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the start edge, with operands scrambled
  // to show they were captured.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
  endtask

  task automatic run_single(input string tag, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    issue(op, a, b);
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    check({tag, " early done"}, 32'(bus.done), 32'd0);
    tick();
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy in done"}, 32'(bus.busy), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(exp));
    tick();
    check({tag, " done drop"}, 32'(bus.done), 32'd0);
    check({tag, " result hold"}, 32'(bus.result), 32'(exp));
  endtask

  task automatic run_mul(input string tag, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    issue(op, a, b);
    for (int i = 0; i < LAT; i++) begin
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " early done"}, 32'(bus.done), 32'd0);
      tick();
    end
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " result"}, 32'(bus.result), 32'(exp));
    tick();
    check({tag, " done drop"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    bus.A     = '0;
    bus.B     = '0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    repeat (2) tick();
    #3 reset_n = 1'b1;
    tick();

    run_single("add", OP_ADD, 8'hFF, 8'h01, 16'h0100);
    run_single("and", OP_AND, 8'hF0, 8'h3C, 16'h0030);
    run_single("xor", OP_XOR, 8'hF0, 8'h3C, 16'h00CC);
    run_single("sub neg", OP_SUB, 8'h03, 8'h05, 16'hFFFE);
    run_single("sub pos", OP_SUB, 8'h05, 8'h03, 16'h0002);

    // mul with ignored start pulses at N+1 and N+2
    issue(OP_MUL, 8'hFF, 8'hFF);
    bus.op    = OP_ADD;
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    bus.start = 1'b1;
    tick();
    check("mul ign1 done", 32'(bus.done), 32'd0);
    check("mul ign1 busy", 32'(bus.busy), 32'd1);
    tick();
    check("mul ign2 done", 32'(bus.done), 32'd0);
    check("mul ign2 busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    tick();
    check("mul done", 32'(bus.done), 32'd1);
    check("mul result", 32'(bus.result), 32'h0000FE01);
    tick();
    check("mul no extra done", 32'(bus.done), 32'd0);
    check("mul idle busy", 32'(bus.busy), 32'd0);
    tick();
    check("mul no late done", 32'(bus.done), 32'd0);

    run_single("rst_op a", OP_RST, 8'h00, 8'h00, 16'h0000);
    run_mul("mac 3x4", OP_MAC, 8'h03, 8'h04, 16'h000C);
    run_mul("mac 5x6", OP_MAC, 8'h05, 8'h06, 16'h002A);
    run_mul("mac ffxff", OP_MAC, 8'hFF, 8'hFF, 16'hFE2B);
    run_single("rst_op b", OP_RST, 8'h00, 8'h00, 16'h0000);
    run_mul("mac 2x2", OP_MAC, 8'h02, 8'h02, 16'h0004);

    // asynchronous reset in the middle of a multiply
    issue(OP_MUL, 8'h10, 8'h10);
    tick();
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort result", 32'(bus.result), 32'd0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no done", 32'(bus.done), 32'd0);
      check("abort result hold", 32'(bus.result), 32'd0);
    end
    run_mul("mac after abort", OP_MAC, 8'h01, 8'h01, 16'h0001);

    // no_op with start held high
    run_single("add pre-nop", OP_ADD, 8'h12, 8'h34, 16'h0046);
    bus.op    = OP_NOP;
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nop busy", 32'(bus.busy), 32'd0);
      check("nop done", 32'(bus.done), 32'd0);
      check("nop result", 32'(bus.result), 32'h00000046);
    end
    bus.start = 1'b0;

    // back-to-back add issued in the DONE cycle
    issue(OP_ADD, 8'h01, 8'h02);
    tick();
    check("b2b first done", 32'(bus.done), 32'd1);
    check("b2b first result", 32'(bus.result), 32'h00000003);
    bus.op    = OP_ADD;
    bus.A     = 8'h10;
    bus.B     = 8'h20;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b gap done", 32'(bus.done), 32'd0);
    check("b2b gap busy", 32'(bus.busy), 32'd1);
    tick();
    check("b2b second done", 32'(bus.done), 32'd1);
    check("b2b second result", 32'(bus.result), 32'h00000030);
    tick();
    check("b2b second drop", 32'(bus.done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
